// File: rtl/opfwd_pkg.sv
// Shared types, instruction field positions and immediate extension for operand_forward_unit.
package opfwd_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned RBITS     = 5;
    localparam int unsigned RS_MSB    = 25;
    localparam int unsigned RS_LSB    = 21;
    localparam int unsigned RT_MSB    = 20;
    localparam int unsigned RT_LSB    = 16;
    localparam int unsigned SHAMT_MSB = 10;
    localparam int unsigned SHAMT_LSB = 6;
    localparam int unsigned IMM_MSB   = 15;
    localparam int unsigned SHAMT_W   = SHAMT_MSB - SHAMT_LSB + 1;
    localparam int unsigned IMM_W     = IMM_MSB + 1;

    typedef struct packed {
        logic             valid;
        logic             pending;
        logic [RBITS-1:0] addr;
        logic [XLEN-1:0]  data;
    } hist_entry_t;

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } fsm_t;

    function automatic logic [XLEN-1:0] imm_ext(input logic [IMM_W-1:0] imm, input logic zext);
        imm_ext = zext ? {{(XLEN-IMM_W){1'b0}}, imm} : {{(XLEN-IMM_W){imm[IMM_MSB]}}, imm};
    endfunction

endpackage

// File: rtl/opfwd_match.sv
// Priority matcher: youngest valid history entry whose address equals i_addr (never register 0).
module opfwd_match
    import opfwd_pkg::*;
#(
    parameter int unsigned FWD_DEPTH = 2
) (
    input  logic [RBITS-1:0]              i_addr,
    input  hist_entry_t [FWD_DEPTH-1:0]   i_hist,
    output logic                          o_hit,
    output logic                          o_pending,
    output logic [XLEN-1:0]               o_data
);

    // Scan oldest to youngest so the youngest match overwrites older ones.
    always_comb begin
        o_hit     = 1'b0;
        o_pending = 1'b0;
        o_data    = '0;
        for (int i = int'(FWD_DEPTH) - 1; i >= 0; i--) begin
            if (i_hist[i].valid && (i_hist[i].addr == i_addr) && (i_addr != '0)) begin
                o_hit     = 1'b1;
                o_pending = i_hist[i].pending;
                o_data    = i_hist[i].data;
            end
        end
    end

endmodule

// File: rtl/operand_forward_unit.sv
// Decode/execute operand forwarding with load-use stall and stall-timeout tracking.
// Optional OPFWD_STATS_EN adds saturating FwdCount/StallCount outputs.
module operand_forward_unit
    import opfwd_pkg::*;
#(
    parameter int unsigned FWD_DEPTH = 2,
    parameter int unsigned MAX_STALL = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      Instruction,
    input  logic [XLEN-1:0]  Drs,
    input  logic [XLEN-1:0]  Drt,
    input  logic             ZeroExtend,
    input  logic             ShiftImmediate,
    input  logic             ALUSrc,
    input  logic             Advance,
    input  logic             WrEn,
    input  logic [RBITS-1:0] WrAddr,
    input  logic [XLEN-1:0]  WrData,
    input  logic             WrIsLoad,
    input  logic             LoadValid,
    input  logic [XLEN-1:0]  LoadData,
    output logic [XLEN-1:0]  RegA,
    output logic [XLEN-1:0]  RegB,
    output logic [XLEN-1:0]  ALUinA,
    output logic [XLEN-1:0]  ALUinB,
    output logic             FwdHitA,
    output logic             FwdHitB,
    output logic             Stall,
    output logic             StallTimeout
`ifdef OPFWD_STATS_EN
    ,
    output logic [31:0]      FwdCount,
    output logic [31:0]      StallCount
`endif
);

    localparam int unsigned CNT_W = $clog2(MAX_STALL + 1) + 1;

    hist_entry_t [FWD_DEPTH-1:0] r_hist;
    hist_entry_t [FWD_DEPTH-1:0] w_filled;
    hist_entry_t [FWD_DEPTH-1:0] w_hist_nxt;
    logic [FWD_DEPTH-1:0]        w_fill_vec;
    logic                        w_found;

    fsm_t             r_state, w_state_nxt;
    logic [CNT_W-1:0] r_stall_cnt, w_cnt_nxt;
    logic             r_timeout, w_timeout_nxt;

    logic [RBITS-1:0] w_rs, w_rt;
    logic [XLEN-1:0]  w_imm, w_data_a, w_data_b;
    logic             w_hit_a, w_hit_b, w_pend_a, w_pend_b, w_stall;
    logic             w_unused_bits;

    assign w_rs          = Instruction[RS_MSB:RS_LSB];
    assign w_rt          = Instruction[RT_MSB:RT_LSB];
    assign w_imm         = imm_ext(Instruction[IMM_MSB:0], ZeroExtend);
    assign w_unused_bits = ^{Instruction[31:RS_MSB+1], Instruction[SHAMT_LSB-1:0]};

    opfwd_match #(.FWD_DEPTH(FWD_DEPTH)) u_match_a (
        .i_addr(w_rs), .i_hist(r_hist), .o_hit(w_hit_a), .o_pending(w_pend_a), .o_data(w_data_a)
    );

    opfwd_match #(.FWD_DEPTH(FWD_DEPTH)) u_match_b (
        .i_addr(w_rt), .i_hist(r_hist), .o_hit(w_hit_b), .o_pending(w_pend_b), .o_data(w_data_b)
    );

    assign w_stall = (w_hit_a && w_pend_a) || (w_hit_b && w_pend_b);
    assign Stall   = w_stall;
    assign FwdHitA = w_hit_a;
    assign FwdHitB = w_hit_b;
    assign RegA    = w_hit_a ? w_data_a : Drs;
    assign RegB    = w_hit_b ? w_data_b : Drt;
    assign ALUinA  = ShiftImmediate ? {{(XLEN-SHAMT_W){1'b0}}, Instruction[SHAMT_MSB:SHAMT_LSB]} : RegA;
    assign ALUinB  = ALUSrc ? w_imm : RegB;
    assign StallTimeout = r_timeout;

    // Oldest valid pending entry is the one a returning load fills.
    always_comb begin
        w_fill_vec = '0;
        w_found    = 1'b0;
        for (int i = int'(FWD_DEPTH) - 1; i >= 0; i--) begin
            if (!w_found && r_hist[i].valid && r_hist[i].pending) begin
                w_fill_vec[i] = 1'b1;
                w_found       = 1'b1;
            end
        end
    end

    // Fill is applied before the shift so it lands at the entry's post-shift slot.
    always_comb begin
        w_filled = r_hist;
        for (int i = 0; i < int'(FWD_DEPTH); i++) begin
            if (LoadValid && w_fill_vec[i]) begin
                w_filled[i].data    = LoadData;
                w_filled[i].pending = 1'b0;
            end
        end
        w_hist_nxt = w_filled;
        if (Advance) begin
            for (int i = 1; i < int'(FWD_DEPTH); i++) begin
                w_hist_nxt[i] = w_filled[i-1];
            end
            w_hist_nxt[0].valid   = WrEn && (WrAddr != '0) && !w_stall;
            w_hist_nxt[0].pending = WrIsLoad;
            w_hist_nxt[0].addr    = WrAddr;
            w_hist_nxt[0].data    = WrData;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_stall_cnt;
        w_timeout_nxt = r_timeout;
        case (r_state)
            RUN: begin
                w_cnt_nxt = '0;
                if (w_stall) w_state_nxt = STALL;
            end
            STALL: begin
                if (r_stall_cnt != '1) w_cnt_nxt = r_stall_cnt + CNT_W'(1);
                if (r_stall_cnt == CNT_W'(MAX_STALL)) w_timeout_nxt = 1'b1;
                if (!w_stall) w_state_nxt = RUN;
            end
            default: w_state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hist      <= '0;
            r_state     <= RUN;
            r_stall_cnt <= '0;
            r_timeout   <= 1'b0;
        end else begin
            r_hist      <= w_hist_nxt;
            r_state     <= w_state_nxt;
            r_stall_cnt <= w_cnt_nxt;
            r_timeout   <= w_timeout_nxt;
        end
    end

`ifdef OPFWD_STATS_EN
    logic [31:0] r_fwd_count, r_stall_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fwd_count   <= '0;
            r_stall_count <= '0;
        end else begin
            if (Advance && (w_hit_a || w_hit_b) && !w_stall && (r_fwd_count != '1))
                r_fwd_count <= r_fwd_count + 32'd1;
            if (w_stall && (r_stall_count != '1))
                r_stall_count <= r_stall_count + 32'd1;
        end
    end

    assign FwdCount   = r_fwd_count;
    assign StallCount = r_stall_count;
`endif

endmodule

// File: tb/tb_operand_forward_unit.sv
// Directed self-checking bench for operand_forward_unit.
module tb_operand_forward_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] Instruction, Drs, Drt, WrData, LoadData;
    logic        ZeroExtend, ShiftImmediate, ALUSrc, Advance, WrEn, WrIsLoad, LoadValid;
    logic [4:0]  WrAddr;
    logic [31:0] RegA, RegB, ALUinA, ALUinB;
    logic        FwdHitA, FwdHitB, Stall, StallTimeout;
`ifdef OPFWD_STATS_EN
    logic [31:0] FwdCount, StallCount;
`endif

    int n_cmp = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    operand_forward_unit dut (
        .clk(clk), .rst_n(rst_n), .Instruction(Instruction), .Drs(Drs), .Drt(Drt),
        .ZeroExtend(ZeroExtend), .ShiftImmediate(ShiftImmediate), .ALUSrc(ALUSrc),
        .Advance(Advance), .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData), .WrIsLoad(WrIsLoad),
        .LoadValid(LoadValid), .LoadData(LoadData), .RegA(RegA), .RegB(RegB),
        .ALUinA(ALUinA), .ALUinB(ALUinB), .FwdHitA(FwdHitA), .FwdHitB(FwdHitB),
        .Stall(Stall), .StallTimeout(StallTimeout)
`ifdef OPFWD_STATS_EN
        , .FwdCount(FwdCount), .StallCount(StallCount)
`endif
    );

    function automatic logic [31:0] mk(input logic [4:0] rs, input logic [4:0] rt, input logic [15:0] imm);
        mk = {6'h08, rs, rt, imm};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        Advance = 1'b0; WrEn = 1'b0; WrIsLoad = 1'b0; WrAddr = 5'd0; WrData = 32'd0;
        LoadValid = 1'b0; LoadData = 32'd0;
    endtask

    task automatic flush_history();
        idle_inputs();
        Instruction = mk(5'd0, 5'd0, 16'd0);
        Advance = 1'b1;
        step(); step();
        Advance = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        idle_inputs();
        ZeroExtend = 1'b0; ShiftImmediate = 1'b0; ALUSrc = 1'b0;
        Instruction = mk(5'd3, 5'd4, 16'd0); Drs = 32'h5; Drt = 32'h6;
        #1 rst_n = 1'b0;
        #2;
        if (Stall !== 1'b0) begin $display("FAIL reset_stall: got %b want 0", Stall); n_mis++; end
        n_cmp++;
        if (FwdHitA !== 1'b0 || FwdHitB !== 1'b0) begin $display("FAIL reset_hit: got %b%b want 00", FwdHitA, FwdHitB); n_mis++; end
        n_cmp++;
        if (RegA !== 32'h5 || RegB !== 32'h6) begin $display("FAIL reset_regs: got %h %h want 5 6", RegA, RegB); n_mis++; end
        n_cmp++;
        if (StallTimeout !== 1'b0) begin $display("FAIL reset_timeout: got %b want 0", StallTimeout); n_mis++; end
        n_cmp++;
        step(); step();
        rst_n = 1'b1;
    endtask

    task automatic test_passthrough();
        Instruction = mk(5'd3, 5'd4, 16'd0); Drs = 32'h5;
        #2;
        if (RegA !== 32'h5 || FwdHitA !== 1'b0 || Stall !== 1'b0) begin
            $display("FAIL pass_a: got %h hit=%b stall=%b want 5 0 0", RegA, FwdHitA, Stall); n_mis++;
        end
        n_cmp++;
        if (ALUinA !== 32'h5) begin $display("FAIL pass_alua: got %h want 5", ALUinA); n_mis++; end
        n_cmp++;
    endtask

    task automatic test_youngest_wins();
        idle_inputs();
        WrEn = 1'b1; WrAddr = 5'd4; WrData = 32'h11; Advance = 1'b1;
        step();
        WrData = 32'h22;
        step();
        idle_inputs();
        Instruction = mk(5'd4, 5'd4, 16'd0); Drs = 32'h99; Drt = 32'h98;
        #2;
        if (RegA !== 32'h22 || FwdHitA !== 1'b1) begin $display("FAIL youngest_a: got %h hit=%b want 22 1", RegA, FwdHitA); n_mis++; end
        n_cmp++;
        if (RegB !== 32'h22 || FwdHitB !== 1'b1) begin $display("FAIL youngest_b: got %h hit=%b want 22 1", RegB, FwdHitB); n_mis++; end
        n_cmp++;
        Advance = 1'b1;
        step();
        Advance = 1'b0;
        #2;
        if (RegA !== 32'h22 || FwdHitA !== 1'b1) begin $display("FAIL oldest_slot: got %h hit=%b want 22 1", RegA, FwdHitA); n_mis++; end
        n_cmp++;
        Advance = 1'b1;
        step();
        Advance = 1'b0;
        #2;
        if (RegA !== 32'h99 || FwdHitA !== 1'b0) begin $display("FAIL aged_out: got %h hit=%b want 99 0", RegA, FwdHitA); n_mis++; end
        n_cmp++;
    endtask

    task automatic test_reg0();
        idle_inputs();
        WrEn = 1'b1; WrAddr = 5'd0; WrData = 32'hFF; Advance = 1'b1;
        step();
        idle_inputs();
        Instruction = mk(5'd0, 5'd0, 16'd0); Drs = 32'h0; Drt = 32'h0;
        #2;
        if (RegA !== 32'h0 || FwdHitA !== 1'b0) begin $display("FAIL reg0_a: got %h hit=%b want 0 0", RegA, FwdHitA); n_mis++; end
        n_cmp++;
        if (RegB !== 32'h0 || FwdHitB !== 1'b0) begin $display("FAIL reg0_b: got %h hit=%b want 0 0", RegB, FwdHitB); n_mis++; end
        n_cmp++;
    endtask

    task automatic test_load_use();
        flush_history();
        WrEn = 1'b1; WrIsLoad = 1'b1; WrAddr = 5'd7; WrData = 32'hBAD; Advance = 1'b1;
        step();
        idle_inputs();
        Instruction = mk(5'd1, 5'd7, 16'd0); Drs = 32'h1; Drt = 32'hAAAA;
        #2;
        if (Stall !== 1'b1 || FwdHitB !== 1'b1) begin $display("FAIL lu_stall: got stall=%b hit=%b want 1 1", Stall, FwdHitB); n_mis++; end
        n_cmp++;
        step();
        if (dut.r_state !== opfwd_pkg::STALL) begin $display("FAIL lu_fsm: got %b want STALL", dut.r_state); n_mis++; end
        n_cmp++;
        LoadValid = 1'b1; LoadData = 32'h1234;
        step();
        LoadValid = 1'b0;
        #2;
        if (Stall !== 1'b0 || RegB !== 32'h1234) begin $display("FAIL lu_fill: got stall=%b regb=%h want 0 1234", Stall, RegB); n_mis++; end
        n_cmp++;
        step();
        if (dut.r_state !== opfwd_pkg::RUN) begin $display("FAIL lu_fsm_run: got %b want RUN", dut.r_state); n_mis++; end
        n_cmp++;
    endtask

    task automatic test_fill_on_advance();
        flush_history();
        WrEn = 1'b1; WrIsLoad = 1'b1; WrAddr = 5'd9; Advance = 1'b1;
        step();
        idle_inputs();
        Instruction = mk(5'd9, 5'd0, 16'd0); Drs = 32'h3;
        Advance = 1'b1; WrEn = 1'b1; WrAddr = 5'd9; WrData = 32'hEE;
        LoadValid = 1'b1; LoadData = 32'h5678;
        #2;
        if (Stall !== 1'b1) begin $display("FAIL fa_stall: got %b want 1", Stall); n_mis++; end
        n_cmp++;
        step();
        idle_inputs();
        #2;
        if (RegA !== 32'h5678 || Stall !== 1'b0 || FwdHitA !== 1'b1) begin
            $display("FAIL fa_fill: got %h stall=%b hit=%b want 5678 0 1", RegA, Stall, FwdHitA); n_mis++;
        end
        n_cmp++;
        LoadValid = 1'b1; LoadData = 32'hDEAD;
        step();
        LoadValid = 1'b0;
        #2;
        if (RegA !== 32'h5678) begin $display("FAIL stray_load: got %h want 5678", RegA); n_mis++; end
        n_cmp++;
    endtask

    task automatic test_imm_shamt();
        flush_history();
        Drs = 32'h77; Drt = 32'h66;
        Instruction = mk(5'd1, 5'd2, 16'h8001); ZeroExtend = 1'b0; ALUSrc = 1'b1;
        #2;
        if (ALUinB !== 32'hFFFF8001) begin $display("FAIL imm_sext: got %h want FFFF8001", ALUinB); n_mis++; end
        n_cmp++;
        ZeroExtend = 1'b1;
        #2;
        if (ALUinB !== 32'h00008001) begin $display("FAIL imm_zext: got %h want 00008001", ALUinB); n_mis++; end
        n_cmp++;
        Instruction = mk(5'd1, 5'd2, 16'h7FFF); ZeroExtend = 1'b0;
        #2;
        if (ALUinB !== 32'h00007FFF) begin $display("FAIL imm_pos: got %h want 00007FFF", ALUinB); n_mis++; end
        n_cmp++;
        ALUSrc = 1'b0;
        #2;
        if (ALUinB !== 32'h66) begin $display("FAIL alub_reg: got %h want 66", ALUinB); n_mis++; end
        n_cmp++;
        Instruction = mk(5'd1, 5'd2, 16'h0240); ShiftImmediate = 1'b1;
        #2;
        if (ALUinA !== 32'd9) begin $display("FAIL shamt: got %h want 9", ALUinA); n_mis++; end
        n_cmp++;
        ShiftImmediate = 1'b0;
        #2;
        if (ALUinA !== 32'h77) begin $display("FAIL alua_reg: got %h want 77", ALUinA); n_mis++; end
        n_cmp++;
    endtask

    task automatic test_timeout();
        flush_history();
        WrEn = 1'b1; WrIsLoad = 1'b1; WrAddr = 5'd7; Advance = 1'b1;
        step();
        idle_inputs();
        Instruction = mk(5'd0, 5'd7, 16'd0); Drt = 32'h4242;
        for (int i = 0; i < 16; i++) step();
        if (StallTimeout !== 1'b0) begin $display("FAIL to_early: got %b want 0", StallTimeout); n_mis++; end
        n_cmp++;
        step();
        if (StallTimeout !== 1'b1) begin $display("FAIL to_set: got %b want 1", StallTimeout); n_mis++; end
        n_cmp++;
        for (int i = 0; i < 8; i++) step();
        if (StallTimeout !== 1'b1 || Stall !== 1'b1) begin $display("FAIL to_sticky: got to=%b stall=%b want 1 1", StallTimeout, Stall); n_mis++; end
        n_cmp++;
        #3 rst_n = 1'b0;
        #1;
        if (Stall !== 1'b0 || StallTimeout !== 1'b0) begin $display("FAIL to_reset: got stall=%b to=%b want 0 0", Stall, StallTimeout); n_mis++; end
        n_cmp++;
        if (RegB !== 32'h4242 || FwdHitB !== 1'b0) begin $display("FAIL to_reset_regb: got %h hit=%b want 4242 0", RegB, FwdHitB); n_mis++; end
        n_cmp++;
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_youngest_wins();
        test_reg0();
        test_load_use();
        test_fill_on_advance();
        test_imm_shamt();
        test_timeout();
        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
